// File: rtl/scan_pkg.sv
// Shared types and defaults for the channel scan controller.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam int unsigned DWELL_W_DEF = 8;

endpackage

// File: rtl/scan_ctrl_next_sel.sv
// Next-channel search: lowest set mask bit strictly above cur, else lowest set bit overall.
module next_sel (
    input  logic [7:0] mask,
    input  logic [2:0] cur,
    output logic [2:0] nxt,
    output logic       wrap
);

    logic [2:0] w_hi;
    logic [2:0] w_lo;
    logic       w_found_hi;

    always_comb begin
        w_hi       = '0;
        w_lo       = '0;
        w_found_hi = 1'b0;
        // Walk from the top down so the last hit is the lowest qualifying bit.
        for (int unsigned k = 0; k < 8; k++) begin
            if (mask[7 - k]) begin
                w_lo = 3'(7 - k);
                if (3'(7 - k) > cur) begin
                    w_hi       = 3'(7 - k);
                    w_found_hi = 1'b1;
                end
            end
        end
    end

    assign nxt  = w_found_hi ? w_hi : w_lo;
    assign wrap = ~w_found_hi;

endmodule

// File: rtl/scan_ctrl.sv
// Scan controller: steps a 3-to-8 decoder through the enabled channels with a
// programmable dwell and a one-cycle break-before-make gap between channels.
module scan_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               done
);

    state_t             r_state;
    logic [2:0]         r_sel;
    logic               r_en;
    logic               r_busy;
    logic               r_done;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_dwell;
    logic [7:0]         r_mask;
    logic               r_mode;

    logic [7:0]         w_srch_mask;
    logic [2:0]         w_srch_cur;
    logic [2:0]         w_nxt;
    logic               w_wrap;

    // One search unit serves both cases: in IDLE, cur=7 yields the lowest set
    // bit of the live mask; otherwise it steps through the captured mask.
    assign w_srch_mask = (r_state == IDLE) ? mask  : r_mask;
    assign w_srch_cur  = (r_state == IDLE) ? 3'd7  : r_sel;

    next_sel u_next_sel (
        .mask (w_srch_mask),
        .cur  (w_srch_cur),
        .nxt  (w_nxt),
        .wrap (w_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_dwell <= '0;
            r_mask  <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_state <= IDLE;
                r_en    <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            if (mask != '0) begin
                                r_state <= RUN;
                                r_sel   <= w_nxt;
                                r_en    <= 1'b1;
                                r_busy  <= 1'b1;
                                r_cnt   <= dwell;
                                r_dwell <= dwell;
                                r_mask  <= mask;
                                r_mode  <= mode;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (r_cnt == '0) begin
                            r_state <= BLANK;
                            r_en    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - DWELL_W'(1);
                        end
                    end
                    BLANK: begin
                        if (w_wrap && !r_mode) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_sel   <= w_nxt;
                            r_en    <= 1'b1;
                            r_cnt   <= r_dwell;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sel  = r_sel;
    assign en   = r_en;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl: cycle-by-cycle vector table plus hand-written corner sequences.
module tb_scan_ctrl;

    typedef struct {
        logic       start;
        logic       stop;
        logic       mode;
        logic [7:0] mask;
        logic [7:0] dwell;
        logic [2:0] sel;
        logic       en;
        logic       busy;
        logic       done;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       en;
    logic       busy;
    logic       done;

    int n_checks;
    int n_err;

    vec_t vecs[30];

    scan_ctrl #(.DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .mask  (mask),
        .dwell (dwell),
        .sel   (sel),
        .en    (en),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int e_sel, input int e_en,
                             input int e_busy, input int e_done);
        check({tag, " sel"},  int'(sel),  e_sel);
        check({tag, " en"},   int'(en),   e_en);
        check({tag, " busy"}, int'(busy), e_busy);
        check({tag, " done"}, int'(done), e_done);
    endtask

    task automatic drive(input logic s, input logic sp, input logic md,
                         input logic [7:0] mk, input logic [7:0] dw);
        start = s;
        stop  = sp;
        mode  = md;
        mask  = mk;
        dwell = dw;
    endtask

    initial begin
        int cnt;
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // start, stop, mode, mask, dwell | sel, en, busy, done
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h85, 8'd2, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h85, 8'd2, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h0F, 8'd0, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd2, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd7, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd7, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd7, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd7, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd7, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd7, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 3'd7, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd7, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 8'h10, 8'd0, 3'd7, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd7, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 8'h81, 8'd1, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd7, 1'b1, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd7, 1'b1, 1'b1, 1'b0};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd7, 1'b0, 1'b1, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[26] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[27] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd7, 1'b1, 1'b1, 1'b0};
        vecs[28] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 3'd7, 1'b0, 1'b0, 1'b0};
        vecs[29] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 3'd7, 1'b0, 1'b0, 1'b0};

        // Reset state before any clock edge
        #3;
        check_out("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_out("post-reset idle", 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].mask, vecs[i].dwell);
            tick();
            check_out($sformatf("vec%0d", i), int'(vecs[i].sel), int'(vecs[i].en),
                      int'(vecs[i].busy), int'(vecs[i].done));
        end

        // One-shot all channels, dwell 0: done 16 cycles after first en
        drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
        for (int ch = 0; ch < 8; ch++) begin
            check_out($sformatf("ff run ch%0d", ch), ch, 1, 1, 0);
            tick();
            check_out($sformatf("ff blank ch%0d", ch), ch, 0, 1, 0);
            tick();
        end
        check_out("ff done", 7, 0, 0, 1);
        tick();
        check_out("ff after done", 7, 0, 0, 0);

        // Maximum dwell: en high for 256 cycles
        drive(1'b1, 1'b0, 1'b0, 8'h40, 8'hFF);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
        cnt = 0;
        while (en && cnt < 300) begin
            cnt++;
            tick();
        end
        check("max dwell en cycles", cnt, 256);
        check_out("max dwell blank", 6, 0, 1, 0);
        tick();
        check_out("max dwell done", 6, 0, 0, 1);

        // Single-bit mask in continuous mode alternates RUN/BLANK on one channel
        drive(1'b1, 1'b0, 1'b1, 8'h08, 8'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
        for (int r = 0; r < 3; r++) begin
            check_out($sformatf("single run%0d", r), 3, 1, 1, 0);
            tick();
            check_out($sformatf("single blank%0d", r), 3, 0, 1, 0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00, 8'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
        check_out("single stopped", 3, 0, 0, 0);

        // Asynchronous reset mid-RUN, then restart from lowest set bit
        drive(1'b1, 1'b0, 1'b1, 8'h0C, 8'd3);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
        tick();
        check_out("pre-async-reset", 2, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        check_out("after async reset", 0, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 8'h0C, 8'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'd0);
        check_out("restart", 2, 1, 1, 0);
        tick();
        check_out("restart blank", 2, 0, 1, 0);
        tick();
        check_out("restart ch3", 3, 1, 1, 0);
        tick();
        tick();
        check_out("restart done", 3, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
